exe_mul_unit: RTL and testbench

- Iterative multi-cycle multiplier in the EXE stage, directly downstream of the ID/EXE pipeline register.
- Consumes the registered multiply enable, val1, val2 and dest from ID/EXE.
- Produces a 2*WIDTH product and a one-cycle result_valid strobe.
- Drives a stall that freezes IF, ID and the ID/EXE register until the product is ready.

---
 rtl/exe_mul_unit_pkg.sv | 19 +
 rtl/exe_mul_unit_if.sv | 27 ++
 rtl/exe_mul_unit_step.sv | 18 +
 rtl/exe_mul_unit.sv | 125 ++++++++++++
 tb/tb_exe_mul_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/exe_mul_unit_pkg.sv
// Shared widths, FSM encoding and operand helper for the EXE-stage iterative multiplier.
package exe_mul_unit_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Magnitude of an operand; -2^(WIDTH-1) maps onto itself, which is the correct unsigned value.
  function automatic logic [WIDTH-1:0] op_mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/exe_mul_unit_if.sv
// ID/EXE-side request and result signals of the multiplier.
interface exe_mul_unit_if;
  import exe_mul_unit_pkg::*;

  logic                  mul_en;
  logic                  is_signed;
  logic                  flush;
  logic [WIDTH-1:0]      val1;
  logic [WIDTH-1:0]      val2;
  logic [REG_ADDR_W-1:0] dest_in;
  logic                  stall;
  logic                  busy;
  logic                  result_valid;
  logic [WIDTH-1:0]      prod_hi;
  logic [WIDTH-1:0]      prod_lo;
  logic [REG_ADDR_W-1:0] dest_out;

  modport master (
    output mul_en, is_signed, flush, val1, val2, dest_in,
    input  stall, busy, result_valid, prod_hi, prod_lo, dest_out
  );

  modport slave (
    input  mul_en, is_signed, flush, val1, val2, dest_in,
    output stall, busy, result_valid, prod_hi, prod_lo, dest_out
  );
endinterface

// File: rtl/exe_mul_unit_step.sv
// One radix-2 shift-add iteration: conditional add into the upper half, then a 1-bit right shift.
module mul_shift_add_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] mplr_i,
  input  logic [W-1:0] mcand_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] mplr_o
);
  logic [W:0] sum;

  always_comb begin
    sum    = {1'b0, acc_i} + (mplr_i[0] ? {1'b0, mcand_i} : (W+1)'(0));
    acc_o  = sum[W:1];
    mplr_o = {sum[0], mplr_i[W-1:1]};
  end
endmodule

// File: rtl/exe_mul_unit.sv
// Iterative signed/unsigned multiplier for the EXE stage; stalls upstream until the product is ready.
module exe_mul_unit
  import exe_mul_unit_pkg::*;
(
  input logic           clk,
  input logic           rst,
  exe_mul_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      mplr_q, mplr_d;
  logic                  neg_q, neg_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [REG_ADDR_W-1:0] dest_out_q, dest_out_d;
  logic [WIDTH-1:0]      prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0]      prod_lo_q, prod_lo_d;
  logic                  result_valid_q, result_valid_d;
  logic                  busy_q, busy_d;

  logic [WIDTH-1:0]      acc_step, mplr_step;
  logic [2*WIDTH-1:0]    prod_mag, prod_fix;
  logic                  start;

  mul_shift_add_step #(.W(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_step),
    .mplr_o  (mplr_step)
  );

  assign start    = (state_q == MUL_IDLE) & bus.mul_en & ~bus.flush;
  assign prod_mag = {acc_step, mplr_step};
  assign prod_fix = neg_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;

  assign bus.stall        = start | (state_q == MUL_BUSY);
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.prod_hi      = prod_hi_q;
  assign bus.prod_lo      = prod_lo_q;
  assign bus.dest_out     = dest_out_q;

  // Next-state and capture logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    acc_d          = acc_q;
    mplr_d         = mplr_q;
    neg_d          = neg_q;
    dest_d         = dest_q;
    dest_out_d     = dest_out_q;
    prod_hi_d      = prod_hi_q;
    prod_lo_d      = prod_lo_q;
    result_valid_d = 1'b0;

    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          mcand_d = op_mag(bus.val1, bus.is_signed);
          mplr_d  = op_mag(bus.val2, bus.is_signed);
          neg_d   = bus.is_signed & (bus.val1[WIDTH-1] ^ bus.val2[WIDTH-1]);
          dest_d  = bus.dest_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (bus.flush) begin
          state_d = MUL_IDLE;
        end else begin
          acc_d  = acc_step;
          mplr_d = mplr_step;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            {prod_hi_d, prod_lo_d} = prod_fix;
            dest_out_d     = dest_q;
            result_valid_d = 1'b1;
            state_d        = MUL_DONE;
          end
        end
      end
      // mul_en seen here still belongs to the instruction just completed
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase

    busy_d = (state_d == MUL_BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= MUL_IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      acc_q          <= '0;
      mplr_q         <= '0;
      neg_q          <= 1'b0;
      dest_q         <= '0;
      dest_out_q     <= '0;
      prod_hi_q      <= '0;
      prod_lo_q      <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      acc_q          <= acc_d;
      mplr_q         <= mplr_d;
      neg_q          <= neg_d;
      dest_q         <= dest_d;
      dest_out_q     <= dest_out_d;
      prod_hi_q      <= prod_hi_d;
      prod_lo_q      <= prod_lo_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end
endmodule

// File: tb/tb_exe_mul_unit.sv
// Scoreboard bench for exe_mul_unit: directed multiplies, flush, mid-op reset, back-to-back timing.
module tb_exe_mul_unit;
  import exe_mul_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  dest;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc_cnt;
  exp_t sb_q[$];

  exe_mul_unit_if bus ();

  exe_mul_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every result_valid pops one expected result
  always @(negedge clk) begin
    if (rst && bus.result_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got result_valid=1 expected no pending result (hi=0x%0h lo=0x%0h)",
                 bus.prod_hi, bus.prod_lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", {bus.prod_hi, bus.prod_lo}, {e.hi, e.lo});
        check("dest_out", 64'(bus.dest_out), 64'(e.dest));
      end
    end
  end

  // Issue one multiply from an IDLE cycle, holding mul_en until the DONE cycle has passed.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [4:0] d, input logic [63:0] exp, output int rv_at);
    int stall_cnt;
    int rv_idx;
    bit busy_ok;
    exp_t e;
    bus.mul_en    = 1'b1;
    bus.is_signed = sgn;
    bus.val1      = a;
    bus.val2      = b;
    bus.dest_in   = d;
    e.hi = exp[63:32];
    e.lo = exp[31:0];
    e.dest = d;
    sb_q.push_back(e);
    stall_cnt = 0;
    rv_idx    = -1;
    rv_at     = -1;
    busy_ok   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if ((i == 0 && bus.busy) || (i >= 1 && i <= 32 && !bus.busy)) busy_ok = 1'b0;
      if (bus.result_valid) begin
        rv_idx = i;
        rv_at  = cyc_cnt;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.mul_en = 1'b0;
    check("stall_cycles", 64'(stall_cnt), 64'd33);
    check("valid_latency", 64'(rv_idx), 64'd33);
    check("busy_window", 64'(busy_ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, tdummy;
    bit rv_seen;
    checks   = 0;
    failures = 0;
    cyc_cnt  = 0;
    rst           = 1'b0;
    bus.mul_en    = 1'b0;
    bus.is_signed = 1'b0;
    bus.flush     = 1'b0;
    bus.val1      = '0;
    bus.val2      = '0;
    bus.dest_in   = '0;

    #12;
    check("reset_product", {bus.prod_hi, bus.prod_lo}, 64'd0);
    check("reset_dest", 64'(bus.dest_out), 64'd0);
    check("reset_ctrl", 64'({bus.result_valid, bus.busy, bus.stall}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_mul(32'd7,        32'd6,        1'b0, 5'd3,  64'h00000000_0000002A, tdummy);
    do_mul(32'hFFFFFFFD, 32'd5,        1'b1, 5'd7,  64'hFFFFFFFF_FFFFFFF1, tdummy);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd9,  64'hFFFFFFFE_00000001, tdummy);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd13, 64'h00000000_00000001, tdummy);
    do_mul(32'd0,        32'h00001234, 1'b0, 5'd14, 64'h00000000_00000000, tdummy);
    do_mul(32'h80000000, 32'h80000000, 1'b1, 5'd12, 64'h40000000_00000000, tdummy);

    // Flush during BUSY: no result, outputs keep the previous product
    bus.mul_en = 1'b1; bus.is_signed = 1'b0;
    bus.val1 = 32'd7; bus.val2 = 32'd6; bus.dest_in = 5'd20;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.mul_en = 1'b0;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_stall", 64'(bus.stall), 64'd0);
    check("flush_busy", 64'(bus.busy), 64'd0);
    rv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid) rv_seen = 1'b1;
    end
    check("flush_no_valid", 64'(rv_seen), 64'd0);
    check("flush_keep_product", {bus.prod_hi, bus.prod_lo}, 64'h40000000_00000000);
    check("flush_keep_dest", 64'(bus.dest_out), 64'd12);

    // Asynchronous reset in the middle of BUSY
    @(posedge clk);
    #1;
    bus.mul_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mul_en = 1'b0;
    #1;
    check("midrst_product", {bus.prod_hi, bus.prod_lo}, 64'd0);
    check("midrst_dest", 64'(bus.dest_out), 64'd0);
    check("midrst_ctrl", 64'({bus.result_valid, bus.busy, bus.stall}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_mul(32'd2, 32'd3, 1'b0, 5'd1, 64'd6, tdummy);

    // Back-to-back: second start in the first IDLE cycle after DONE
    do_mul(32'd2, 32'd3, 1'b0, 5'd2, 64'd6,  t1);
    do_mul(32'd4, 32'd5, 1'b0, 5'd4, 64'd20, t2);
    check("b2b_spacing", 64'(t2 - t1), 64'd34);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
